// File: rtl/lane_serializer.sv
// Two-lane LSB-first serializer with a one-symbol holding buffer for gapless streaming.
// Optional sticky overflow detection is built when LANE_SER_OVF_DET_EN is defined.
module lane_serializer (
  input  logic         enc_clk,
  input  logic         rst,
  input  logic         enable_ser,
  input  logic         new_sym,
  input  logic [1:0]   gen_speed,
  input  logic [131:0] lane_0_tx_enc_old,
  input  logic [131:0] lane_1_tx_enc_old,
  output logic         lane_0_tx_bit,
  output logic         lane_1_tx_bit,
  output logic         tx_valid,
  output logic         sym_start,
  output logic         hold_ready,
  output logic         ovf_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state, state_nxt;
  logic [131:0]   hold_0, hold_1;
  logic [131:0]   shift_0, shift_1;
  logic [1:0]     hold_gen;
  logic           hold_full;
  logic [7:0]     bit_cnt;
  logic [7:0]     cur_last;
  logic           load, transfer, discard;

  function automatic logic [7:0] last_idx(input logic [1:0] gen);
    case (gen)
      2'd2:    last_idx = 8'd65;
      2'd1:    last_idx = 8'd131;
      default: last_idx = 8'd7;
    endcase
  endfunction

  always_ff @(posedge enc_clk) begin
    if (!rst || !enable_ser) state <= IDLE;
    else                     state <= state_nxt;
  end

  // A buffered reserved-length word is dropped rather than shifted.
  always_comb begin
    state_nxt = state;
    transfer  = 1'b0;
    discard   = 1'b0;
    load      = enable_ser & new_sym;
    case (state)
      IDLE: begin
        if (hold_full) begin
          if (hold_gen == 2'd3) begin
            discard = 1'b1;
          end else begin
            transfer  = 1'b1;
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (bit_cnt == 8'd0) begin
          if (hold_full && hold_gen != 2'd3) begin
            transfer = 1'b1;
          end else begin
            discard   = hold_full;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    tx_valid      = (state == SHIFT);
    lane_0_tx_bit = tx_valid & shift_0[0];
    lane_1_tx_bit = tx_valid & shift_1[0];
    sym_start     = tx_valid && (bit_cnt == cur_last);
    hold_ready    = ~hold_full;
  end

  // Control stage: buffer occupancy and bit counter
  always_ff @(posedge enc_clk) begin
    if (!rst || !enable_ser) begin
      hold_full <= 1'b0;
      bit_cnt   <= 8'd0;
      cur_last  <= 8'd0;
    end else begin
      if (load)                     hold_full <= 1'b1;
      else if (transfer || discard) hold_full <= 1'b0;
      if (transfer) begin
        bit_cnt  <= last_idx(hold_gen);
        cur_last <= last_idx(hold_gen);
      end else if (state == SHIFT && bit_cnt != 8'd0) begin
        bit_cnt <= bit_cnt - 8'd1;
      end
    end
  end

  // Data stage: transfer reads the old buffer before a same-edge load replaces it
  always_ff @(posedge enc_clk) begin
    if (load) begin
      hold_0   <= lane_0_tx_enc_old;
      hold_1   <= lane_1_tx_enc_old;
      hold_gen <= gen_speed;
    end
    if (transfer) begin
      shift_0 <= hold_0;
      shift_1 <= hold_1;
    end else if (state == SHIFT) begin
      shift_0 <= shift_0 >> 1;
      shift_1 <= shift_1 >> 1;
    end
  end

`ifdef LANE_SER_OVF_DET_EN
  always_ff @(posedge enc_clk) begin
    if (!rst)                                           ovf_err <= 1'b0;
    else if (load && hold_full && !(transfer || discard)) ovf_err <= 1'b1;
  end
`else
  assign ovf_err = 1'b0;
`endif

endmodule
